trail_writer: RTL and testbench

- Write-side master for the shared frameRAM frame buffer: 640x480 pixels, 4-bit colour enum, two pixels per 16-bit word.
- After reset or on request, sweeps the whole buffer to the background colour.
- Afterwards, on every frame_clk rising edge, stamps the current blue and red bike positions into the buffer as trail pixels.
- Drives the buffer's write_address / Data_In / WE; the display read path is untouched.

---
 rtl/trail_writer.sv | 146 ++++++++++++++
 tb/tb_trail_writer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/trail_writer.sv
// Write-side master for the shared frame buffer: clears it to the background
// colour, then stamps the blue and red bike positions on every frame tick.
module trail_writer #(
  parameter int         H_RES      = 640,
  parameter int         V_RES      = 480,
  parameter logic [3:0] BG_COLOR   = 4'h0,
  parameter logic [3:0] BLUE_COLOR = 4'h1,
  parameter logic [3:0] RED_COLOR  = 4'h2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        clear_req,
  input  logic [9:0]  Blue_X,
  input  logic [9:0]  Blue_Y,
  input  logic [9:0]  Red_X,
  input  logic [9:0]  Red_Y,
  input  logic        blue_alive,
  input  logic        red_alive,
  output logic [18:0] write_address,
  output logic [15:0] Data_Out,
  output logic        WE,
  output logic        busy,
  output logic        clear_done
);

  localparam int          HALF  = H_RES / 2;
  localparam logic [18:0] LAST  = 19'(HALF * V_RES - 1);
  localparam logic [9:0]  H_LIM = 10'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);

  typedef enum logic [1:0] {CLEAR, IDLE, WR_BLUE, WR_RED} state_t;

  state_t      state_q;
  logic [18:0] cnt_q;
  logic        clear_pend_q;
  logic        fsync1_q, fsync2_q, fprev_q;
  logic [9:0]  bx_q, by_q, rx_q, ry_q;
  logic        balive_q, ralive_q;
  logic [18:0] addr_q;
  logic [15:0] data_q;
  logic        we_q, busy_q, clear_done_q;
  logic        frame_tick;

  assign frame_tick = fsync2_q & ~fprev_q;

  function automatic logic [18:0] word_addr(input logic [9:0] x, input logic [9:0] y);
    return 19'(y) * 19'(HALF) + 19'(x[9:1]);
  endfunction

  function automatic logic [15:0] word_of(input logic [3:0] c);
    return {4'h0, c, 4'h0, c};
  endfunction

  function automatic logic on_screen(input logic [9:0] x, input logic [9:0] y);
    return (x < H_LIM) && (y < V_LIM);
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      clear_pend_q <= 1'b0;
      fsync1_q     <= 1'b0;
      fsync2_q     <= 1'b0;
      fprev_q      <= 1'b0;
      bx_q         <= '0;
      by_q         <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      balive_q     <= 1'b0;
      ralive_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      fsync1_q     <= frame_clk;
      fsync2_q     <= fsync1_q;
      fprev_q      <= fsync2_q;
      clear_done_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          we_q   <= 1'b1;
          addr_q <= cnt_q;
          data_q <= word_of(BG_COLOR);
          busy_q <= 1'b1;
          if (cnt_q == LAST) begin
            cnt_q        <= '0;
            state_q      <= IDLE;
            clear_done_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 19'd1;
          end
        end
        IDLE: begin
          we_q <= 1'b0;
          // A clear request beats a simultaneous tick; the tick is lost.
          if (clear_req || clear_pend_q) begin
            clear_pend_q <= 1'b0;
            state_q      <= CLEAR;
            busy_q       <= 1'b1;
          end else if (frame_tick) begin
            bx_q     <= Blue_X;
            by_q     <= Blue_Y;
            rx_q     <= Red_X;
            ry_q     <= Red_Y;
            balive_q <= blue_alive;
            ralive_q <= red_alive;
            state_q  <= WR_BLUE;
            busy_q   <= 1'b1;
          end
        end
        WR_BLUE: begin
          we_q <= balive_q && on_screen(bx_q, by_q);
          if (balive_q && on_screen(bx_q, by_q)) begin
            addr_q <= word_addr(bx_q, by_q);
            data_q <= word_of(BLUE_COLOR);
          end
          if (clear_req) clear_pend_q <= 1'b1;
          state_q <= WR_RED;
          busy_q  <= 1'b1;
        end
        default: begin
          we_q <= ralive_q && on_screen(rx_q, ry_q);
          if (ralive_q && on_screen(rx_q, ry_q)) begin
            addr_q <= word_addr(rx_q, ry_q);
            data_q <= word_of(RED_COLOR);
          end
          if (clear_req) clear_pend_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign write_address = addr_q;
  assign Data_Out      = data_q;
  assign WE            = we_q;
  assign busy          = busy_q;
  assign clear_done    = clear_done_q;

endmodule

// File: tb/tb_trail_writer.sv
// Scoreboard bench for trail_writer on a reduced 64x48 buffer (1536 words):
// stimulus queues expected writes, a negedge monitor pops and compares them.
module tb_trail_writer;

  localparam int H = 64;
  localparam int V = 48;
  localparam int WORDS = H / 2 * V;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        clear_req = 1'b0;
  logic [9:0]  Blue_X = '0, Blue_Y = '0, Red_X = '0, Red_Y = '0;
  logic        blue_alive = 1'b0, red_alive = 1'b0;
  logic [18:0] write_address;
  logic [15:0] Data_Out;
  logic        WE, busy, clear_done;

  trail_writer #(.H_RES(H), .V_RES(V)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .clear_req(clear_req),
    .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
    .blue_alive(blue_alive), .red_alive(red_alive),
    .write_address(write_address), .Data_Out(Data_Out), .WE(WE),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 Clk = ~Clk;

  logic [34:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int done_cnt = 0;

  always @(negedge Clk) begin
    if (!Reset && clear_done) done_cnt++;
    if (!Reset && WE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", write_address, Data_Out);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        pops++;
        if ({write_address, Data_Out} !== e) begin
          errors++;
          $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                   write_address, Data_Out, e[34:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int addr, input logic [15:0] data);
    exp_q.push_back({19'(addr), data});
  endtask

  task automatic push_clear();
    for (int i = 0; i < WORDS; i++) push(i, 16'h0000);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    cycles(4);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic stamp(input int bx, input int by, input int rx, input int ry,
                       input logic ba, input logic ra);
    Blue_X = 10'(bx); Blue_Y = 10'(by); Red_X = 10'(rx); Red_Y = 10'(ry);
    blue_alive = ba; red_alive = ra;
    frame_clk = 1'b1;
    cycles(8);
    frame_clk = 1'b0;
    cycles(4);
  endtask

  initial begin
    int d0, n, base;
    #1;
    check("reset_we", WE, 0);
    check("reset_busy", busy, 0);
    check("reset_done", clear_done, 0);
    check("reset_addr", write_address, 0);
    check("reset_data", Data_Out, 0);

    push_clear();
    @(negedge Clk);
    Reset = 1'b0;
    drain("initial_clear", WORDS + 20);
    check("busy_after_clear", busy, 0);
    check("done_after_clear", done_cnt, 1);

    push(165, 16'h0101); push(655, 16'h0202);
    stamp(10, 5, 31, 20, 1'b1, 1'b1);
    drain("both_alive", 20);

    push(1535, 16'h0202);
    stamp(10, 5, 63, 47, 1'b0, 1'b1);
    drain("blue_dead_corner", 20);

    push(0, 16'h0202);
    stamp(70, 5, 0, 0, 1'b1, 1'b1);
    drain("blue_x_offscreen", 20);

    push(0, 16'h0101);
    stamp(1, 0, 5, 48, 1'b1, 1'b1);
    drain("red_y_offscreen", 20);

    push(67, 16'h0101); push(67, 16'h0202);
    stamp(6, 2, 7, 2, 1'b1, 1'b1);
    drain("same_word", 20);

    // clear request while the blue slot is on the bus
    d0 = done_cnt;
    push(33, 16'h0101); push(34, 16'h0202); push_clear();
    Blue_X = 10'd2; Blue_Y = 10'd1; Red_X = 10'd4; Red_Y = 10'd1;
    blue_alive = 1'b1; red_alive = 1'b1;
    frame_clk = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge Clk); n++; end
    check("busy_rise_seen", busy, 1);
    clear_req = 1'b1;
    @(negedge Clk);
    clear_req = 1'b0;
    cycles(6);
    frame_clk = 1'b0;
    cycles(40);
    frame_clk = 1'b1;
    cycles(8);
    frame_clk = 1'b0;
    clear_req = 1'b1;
    @(negedge Clk);
    clear_req = 1'b0;
    drain("pend_clear", WORDS + 40);
    check("pend_clear_done", done_cnt, d0 + 1);

    // reset in the middle of a sweep
    d0 = done_cnt;
    push_clear();
    base = pops;
    clear_req = 1'b1;
    @(negedge Clk);
    clear_req = 1'b0;
    n = 0;
    while (pops - base < 500 && n < 2000) begin @(negedge Clk); n++; end
    check("mid_sweep_words", pops - base, 500);
    #2 Reset = 1'b1;
    #1;
    check("reset_mid_we", WE, 0);
    check("reset_mid_busy", busy, 0);
    exp_q.delete();
    push_clear();
    cycles(3);
    Reset = 1'b0;
    drain("restart_clear", WORDS + 20);
    check("restart_done_once", done_cnt, d0 + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
